// File: rtl/voice_norm_pkg.sv
// Shared types and helpers for the voice normaliser.
// Mode and state encodings plus a popcount used for divisor selection.
package voice_norm_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      NORM_ACTIVE = 2'b00,
      NORM_FIXED  = 2'b01,
      NORM_BYPASS = 2'b10
   } norm_mode_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      DIVIDE = 2'b01,
      DONE   = 2'b10
   } norm_state_t;

   // Number of set bits in a 32-bit word; callers zero-extend narrower masks.
   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         n = n + {31'b0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/voice_normalizer_divider.sv
// Serial restoring divider, one quotient bit per cycle, MSB first.
// Runs exactly DIVIDEND_WIDTH iterations after start; no early exit.
module restoring_divider
   import voice_norm_pkg::*;
#(
   parameter int DIVIDEND_WIDTH = 19,
   parameter int DIVISOR_WIDTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      done,
   output logic [DIVIDEND_WIDTH-1:0] quotient
);

   localparam int CW = $clog2(DIVIDEND_WIDTH);

   logic                      busy;
   logic [CW-1:0]             count;
   logic [DIVISOR_WIDTH-1:0]  dvsr;
   logic [DIVISOR_WIDTH-1:0]  rem;
   logic [DIVIDEND_WIDTH-1:0] shreg;
   logic [DIVISOR_WIDTH:0]    trial;
   logic                      fits;
   logic [DIVISOR_WIDTH-1:0]  rem_nx;

   // Trial subtraction of the divisor from the shifted partial remainder.
   always_comb begin
      trial  = {rem, shreg[DIVIDEND_WIDTH-1]};
      fits   = (trial >= {1'b0, dvsr});
      rem_nx = trial[DIVISOR_WIDTH-1:0];
      if (fits) begin
         rem_nx = DIVISOR_WIDTH'(trial - {1'b0, dvsr});
      end
   end

   assign done     = busy && (count == '0);
   assign quotient = shreg;

   // Load on start, then shift quotient bits into the dividend register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy  <= 1'b0;
         count <= '0;
         dvsr  <= '0;
         rem   <= '0;
         shreg <= '0;
      end else if (start) begin
         busy  <= 1'b1;
         count <= CW'(DIVIDEND_WIDTH - 1);
         dvsr  <= divisor;
         rem   <= '0;
         shreg <= dividend;
      end else if (busy) begin
         rem   <= rem_nx;
         shreg <= {shreg[DIVIDEND_WIDTH-2:0], fits};
         if (count == '0) begin
            busy <= 1'b0;
         end else begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/voice_normalizer.sv
// Normalises the summed voice bus to the sample width.
// Selects a divisor, divides serially, saturates and flags overruns.
module voice_normalizer
   import voice_norm_pkg::*;
#(
   parameter int NUM_VOICES   = 8,
   parameter int SAMPLE_WIDTH = 16,
   parameter int SUM_WIDTH    = 19
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic [SUM_WIDTH-1:0]    sum_in,
   input  logic [NUM_VOICES-1:0]   is_on_in,
   input  logic [1:0]              mode_in,
   input  logic                    valid_in,
   input  logic                    clear_in,
   output logic                    ready_out,
   output logic [SAMPLE_WIDTH-1:0] sample_out,
   output logic                    valid_out,
   output logic                    clip_out,
   output logic                    overrun_out
);

   localparam int DIV_W = $clog2(NUM_VOICES + 1);

   norm_state_t            state;
   norm_state_t            state_nx;
   logic                   capture;
   logic [DIV_W-1:0]       divisor;
   int unsigned            active;
   logic                   div_done;
   logic [SUM_WIDTH-1:0]   quotient;
   logic                   sat;

   assign ready_out = (state == IDLE);
   assign capture   = valid_in && ready_out;
   assign sat       = |quotient[SUM_WIDTH-1:SAMPLE_WIDTH];

   // Divisor from the mode; an empty voice mask divides by one.
   always_comb begin
      active  = popcount(32'(is_on_in));
      divisor = DIV_W'(active);
      if (active == 0) begin
         divisor = DIV_W'(1);
      end
      case (mode_in)
         NORM_FIXED:  divisor = DIV_W'(NUM_VOICES);
         NORM_BYPASS: divisor = DIV_W'(1);
         default:     ;
      endcase
   end

   restoring_divider #(
      .DIVIDEND_WIDTH(SUM_WIDTH),
      .DIVISOR_WIDTH (DIV_W)
   ) u_div (
      .clk     (clk_in),
      .rst_n   (rst_n_in),
      .start   (capture),
      .dividend(sum_in),
      .divisor (divisor),
      .done    (div_done),
      .quotient(quotient)
   );

   // State register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state: wait for a sample, divide, then publish for one cycle.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (valid_in) state_nx = DIVIDE;
         DIVIDE:  if (div_done) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output sample with saturation; strobes last a single cycle.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sample_out <= '0;
         valid_out  <= 1'b0;
         clip_out   <= 1'b0;
      end else if (state == DONE) begin
         sample_out <= sat ? '1 : quotient[SAMPLE_WIDTH-1:0];
         valid_out  <= 1'b1;
         clip_out   <= sat;
      end else begin
         valid_out  <= 1'b0;
         clip_out   <= 1'b0;
      end
   end

   // Sticky overrun; a new overrun beats a simultaneous clear.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         overrun_out <= 1'b0;
      end else if (valid_in && !ready_out) begin
         overrun_out <= 1'b1;
      end else if (clear_in) begin
         overrun_out <= 1'b0;
      end
   end

endmodule

// File: doc/voice_normalizer.md
# voice_normalizer

Normalises the summed oscillator bus to the output sample width before the audio output stage. It divides the pre-division sum by one of three divisors: the number of active voices, the fixed voice count, or 1 (bypass). The quotient saturates to the sample range. A serial restoring divider gives a constant latency, with a valid/ready sample handshake, overrun detection and clip reporting.

## Interface
- NUM_VOICES, 8: number of oscillator voices; width of is_on_in
- SAMPLE_WIDTH, 16: output sample width, unsigned offset-binary
- SUM_WIDTH, 19: pre-division sum width; must be ≥ SAMPLE_WIDTH + $clog2(NUM_VOICES)
- clk_in  input  1  system clock; one clock domain
- rst_n_in  input  1  asynchronous, active-low reset
- sum_in  input  SUM_WIDTH  unsigned sum of voice samples
- is_on_in  input  NUM_VOICES  per-voice active mask
- mode_in  input  2  00 = divide by active count, 01 = divide by NUM_VOICES, 10 = bypass (divide by 1), 11 = treated as 00
- valid_in  input  1  sample strobe; sum_in, is_on_in and mode_in are captured when valid_in && ready_out
- clear_in  input  1  clears overrun_out
- ready_out  output  1  high only in IDLE
- sample_out  output  SAMPLE_WIDTH  normalised sample; holds its value between results
- valid_out  output  1  one-cycle pulse when sample_out updates
- clip_out  output  1  one-cycle pulse, coincident with valid_out, when the result saturated
- overrun_out  output  1  sticky; set when valid_in arrives while ready_out is low

## Operation
- Divisor selection, evaluated from the captured values:
  - Mode 00: popcount(is_on). A popcount of 0 gives divisor 1.
  - Mode 01: NUM_VOICES.
  - Mode 10: 1.
- Divisor width is $clog2(NUM_VOICES+1) bits. The divisor is never 0.
- Divide step: restoring, one quotient bit per cycle, MSB first, SUM_WIDTH iterations. The quotient is SUM_WIDTH bits and the remainder is discarded (truncating division).
- Saturation:
  - If quotient ≥ 2^SAMPLE_WIDTH, sample_out = all ones and clip_out pulses.
  - Otherwise sample_out = quotient[SAMPLE_WIDTH-1:0].
- State machine:
  - IDLE → DIVIDE on valid_in. Capture the dividend and divisor; load the iteration counter with SUM_WIDTH-1.
  - DIVIDE stays while the counter is not 0, decrementing once per cycle. It moves to DONE after the iteration with counter = 0.
  - DONE → IDLE unconditionally. Register sample_out, pulse valid_out and (if saturated) clip_out.
- Latency is constant in every mode, including bypass and divisor 1. There is no early exit.
- Overrun:
  - valid_in in DIVIDE or DONE is ignored; the in-flight sample is unaffected. It sets overrun_out.
  - clear_in clears overrun_out. If clear_in and a new overrun occur in the same cycle, set wins.
- Mode or is_on changes during a division have no effect until the next capture.

## Timing
- Capture edge = edge 0.
- Edges 1..SUM_WIDTH perform the iterations. Edge SUM_WIDTH moves to DONE.
- Edge SUM_WIDTH+1 registers the result; valid_out is high for the following cycle.
- Latency is SUM_WIDTH+1 cycles (20 at defaults). ready_out returns high in the same cycle valid_out is high.
- Maximum throughput is one sample per SUM_WIDTH+1 cycles. The sample strobe period must be at least that.
- Reset (asynchronous assert, at any time including mid-division):
  - state = IDLE
  - sample_out = 0, valid_out = 0, clip_out = 0, overrun_out = 0
  - ready_out = 1 once reset releases
  - The in-flight result is lost and no valid_out is produced for it.
- Reset deassertion is synchronised externally. The first capture may occur on the first edge after release.

## Structure
- Package voice_norm_pkg:
  - norm_mode_t enum: NORM_ACTIVE, NORM_FIXED, NORM_BYPASS
  - norm_state_t enum: IDLE, DIVIDE, DONE
  - function popcount
- Sub-module restoring_divider (parameters DIVIDEND_WIDTH, DIVISOR_WIDTH):
  - start/done handshake and iterative datapath
  - same asynchronous active-low reset
- The top-level block holds divisor selection, saturation, the output registers and the overrun flag.

## Test plan
All scenarios use default parameters.
- Mode 00, is_on = 0000_0111, sum = 30000 → sample_out = 10000, valid_out one cycle exactly 20 cycles after capture, clip_out = 0.
- Mode 00, is_on = 0, sum = 1234 → 1234. Mode 01, sum = 524280 → 65535 with no clip. Mode 01, sum = 7 → 0.
- Mode 10, sum = 70000 → 65535, clip_out pulses with valid_out. Mode 10, sum = 65535 → 65535 with no clip.
- valid_in at cycle 5 of a division:
  - the first result is unchanged and the second sample is dropped
  - overrun_out = 1 until clear_in
  - clear_in plus a new overrun in the same cycle leaves overrun_out = 1
- rst_n_in low at cycle 7 of a division:
  - outputs go to 0 immediately (asynchronously) and no valid_out follows
  - after release, sum = 800, is_on = 0x0F, mode 00 → 200 after 20 cycles
- Back-to-back: valid_in in the cycle valid_out is high → accepted, no overrun; the second result follows 20 cycles later.
